// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch (IF) and data access (MEM).
// Serialises accesses, holds SRAM controls for WAIT_CYCLES cycles, then pulses ready once.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_freeze,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic       r_owner_mem;
  logic       r_op_wr;
  logic       r_last_mem;

  logic       w_mem_req;
  logic       w_any_req;
  logic       w_grant_mem;

  assign w_mem_req   = mem_r_en | mem_w_en;
  assign w_any_req   = w_mem_req | if_req;
  // MEM wins a tie unless it had the previous grant, giving strict alternation under contention.
  assign w_grant_mem = w_mem_req & (~if_req | ~r_last_mem);

  assign if_freeze  = if_req & ~if_ready;
  assign mem_freeze = w_mem_req & ~mem_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next_state = S_BUSY;
        else           w_next_state = S_IDLE;
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) w_next_state = S_RESP;
        else               w_next_state = S_BUSY;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_owner_mem <= 1'b0;
      r_op_wr     <= 1'b0;
      r_last_mem  <= 1'b0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      sram_we     <= 1'b0;
      sram_oe     <= 1'b0;
      if_ready    <= 1'b0;
      mem_ready   <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_mem <= w_grant_mem;
            r_op_wr     <= w_grant_mem & mem_w_en;
            r_last_mem  <= w_grant_mem;
            r_cnt       <= 4'(WAIT_CYCLES - 1);
            sram_addr   <= w_grant_mem ? mem_addr : if_addr;
            if (w_grant_mem) sram_wdata <= mem_wdata;
            sram_we     <= w_grant_mem & mem_w_en;
            sram_oe     <= ~(w_grant_mem & mem_w_en);
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            sram_we <= 1'b0;
            sram_oe <= 1'b0;
            // Read data is only valid in this final BUSY cycle.
            if (!r_op_wr) begin
              if (r_owner_mem) mem_rdata <= sram_rdata;
              else             if_rdata  <= sram_rdata;
            end
            if_ready  <= ~r_owner_mem;
            mem_ready <= r_owner_mem;
          end
        end
        S_RESP: begin
          sram_we <= 1'b0;
          sram_oe <= 1'b0;
        end
        default: begin
          sram_we <= 1'b0;
          sram_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
